// File: rtl/useq_ctrl.sv
// Microprogram sequencer for the cosine-similarity datapath: owns the micro-PC,
// decodes ROM words into datapath enables and loops the body once per vector index.
module useq_ctrl #(
    parameter int unsigned W  = 4,
    parameter int unsigned IW = 8,
    parameter int unsigned UW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] vec_len,
    input  logic          stall,
    output logic [W-1:0]  uaddr,
    input  logic [UW-1:0] uinstr,
    output logic          jump,
    output logic          acc_clr,
    output logic          mul_en,
    output logic          acc_en,
    output logic          sq_en,
    output logic          wr_en,
    output logic [IW-1:0] idx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [W-1:0] UADDR_MAX = {W{1'b1}};

    state_t        state, state_nx;
    logic [W-1:0]  uaddr_nx;
    logic [IW-1:0] idx_nx;
    logic [IW-1:0] len_q, len_nx;
    logic [IW-1:0] last_idx;
    logic          err_nx;
    logic          last_c;

    // Only bits [7:2] carry fields; the rest of the word is don't-care.
    logic unused_uinstr;
    assign unused_uinstr = ^uinstr;

    assign last_c   = uinstr[7];
    assign last_idx = len_q - IW'(1);

    // State and sequencer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            uaddr <= '0;
            idx   <= '0;
            len_q <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            uaddr <= uaddr_nx;
            idx   <= idx_nx;
            len_q <= len_nx;
            err   <= err_nx;
        end
    end

    // Next-state, micro-PC update and zero-latency enable decode
    always_comb begin
        state_nx = state;
        uaddr_nx = uaddr;
        idx_nx   = idx;
        len_nx   = len_q;
        err_nx   = err;
        jump     = 1'b0;
        acc_clr  = 1'b0;
        mul_en   = 1'b0;
        acc_en   = 1'b0;
        sq_en    = 1'b0;
        wr_en    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    len_nx   = vec_len;
                    uaddr_nx = '0;
                    idx_nx   = '0;
                    err_nx   = 1'b0;
                    state_nx = (vec_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    acc_clr = uinstr[6];
                    mul_en  = uinstr[5];
                    acc_en  = uinstr[4];
                    sq_en   = uinstr[3];
                    wr_en   = uinstr[2];
                    if (last_c) begin
                        if (idx != last_idx) begin
                            jump     = 1'b1;
                            uaddr_nx = '0;
                            idx_nx   = idx + IW'(1);
                        end else begin
                            state_nx = FIN;
                        end
                    end else if (uaddr == UADDR_MAX) begin
                        // Body ran off the end of the ROM without a LAST word.
                        err_nx   = 1'b1;
                        state_nx = FIN;
                    end else begin
                        uaddr_nx = uaddr + W'(1);
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

endmodule

// File: tb/tb_useq_ctrl.sv
// Self-checking bench for useq_ctrl: directed vector table, hand sequences for
// reset/overflow, and randomized runs checked against a trace-list model.
module tb_useq_ctrl;

    localparam int unsigned W     = 4;
    localparam int unsigned IW    = 8;
    localparam int unsigned UW    = 8;
    localparam int unsigned DEPTH = 1 << W;

    logic          clk = 1'b0;
    logic          rst, start, stall;
    logic [IW-1:0] vec_len;
    logic [W-1:0]  uaddr;
    logic [UW-1:0] uinstr;
    logic          jump, acc_clr, mul_en, acc_en, sq_en, wr_en;
    logic [IW-1:0] idx;
    logic          busy, done, err;
    logic [4:0]    en;
    logic [UW-1:0] rom [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign uinstr = rom[uaddr];
    assign en     = {acc_clr, mul_en, acc_en, sq_en, wr_en};

    useq_ctrl #(.W(W), .IW(IW), .UW(UW)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .stall(stall),
        .uaddr(uaddr), .uinstr(uinstr), .jump(jump), .acc_clr(acc_clr),
        .mul_en(mul_en), .acc_en(acc_en), .sq_en(sq_en), .wr_en(wr_en),
        .idx(idx), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic          st;
        logic          sl;
        logic [IW-1:0] len;
        logic [W-1:0]  ua;
        logic [IW-1:0] ix;
        logic          j;
        logic          b;
        logic          d;
        logic [4:0]    en;
        logic          e;
    } vec_t;

    typedef struct {
        logic [W-1:0]  ua;
        logic [IW-1:0] ix;
        logic          j;
        logic [4:0]    en;
    } exp_t;

    vec_t tbl[$];

    function automatic void add(input logic st, input logic sl, input int len,
                                input int ua, input int ix, input logic j,
                                input logic b, input logic d, input logic [4:0] e5,
                                input logic e);
        vec_t v;
        v.st = st; v.sl = sl; v.len = IW'(len);
        v.ua = W'(ua); v.ix = IW'(ix);
        v.j = j; v.b = b; v.d = d; v.en = e5; v.e = e;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] ua, input logic [IW-1:0] ix,
                             input logic j, input logic b, input logic d,
                             input logic [4:0] e5, input logic e);
        chk({tag, ".uaddr"}, 32'(uaddr), 32'(ua));
        chk({tag, ".idx"},   32'(idx),   32'(ix));
        chk({tag, ".jump"},  32'(jump),  32'(j));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".en"},    32'(en),    32'(e5));
        chk({tag, ".err"},   32'(err),   32'(e));
    endtask

    task automatic drive(input logic st, input logic sl, input logic [IW-1:0] len);
        start   = st;
        stall   = sl;
        vec_len = len;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        for (int p = 0; p < int'(DEPTH); p++) rom[p] = '0;
        rom[0] = 8'h40;
        rom[1] = 8'h38;
        rom[2] = 8'h84;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        load_basic();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle for 10 cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_all($sformatf("idle%0d", c), '0, '0, 0, 0, 0, 5'b0, 0);
            advance();
        end

        // Basic loop, vec_len=3, with an ignored start mid-run
        add(1,0,3, 0,0,0,0,0,5'b00000,0);
        add(0,0,0, 0,0,0,1,0,5'b10000,0);
        add(0,0,0, 1,0,0,1,0,5'b01110,0);
        add(0,0,0, 2,0,1,1,0,5'b00001,0);
        add(0,0,0, 0,1,0,1,0,5'b10000,0);
        add(1,0,7, 1,1,0,1,0,5'b01110,0);
        add(0,0,0, 2,1,1,1,0,5'b00001,0);
        add(0,0,0, 0,2,0,1,0,5'b10000,0);
        add(0,0,0, 1,2,0,1,0,5'b01110,0);
        add(0,0,0, 2,2,0,1,0,5'b00001,0);
        add(0,0,0, 2,2,0,0,1,5'b00000,0);
        add(0,0,0, 2,2,0,0,0,5'b00000,0);
        // Stall three cycles at uaddr=1, vec_len=2
        add(1,0,2, 2,2,0,0,0,5'b00000,0);
        add(0,0,0, 0,0,0,1,0,5'b10000,0);
        add(0,1,0, 1,0,0,1,0,5'b00000,0);
        add(0,1,0, 1,0,0,1,0,5'b00000,0);
        add(0,1,0, 1,0,0,1,0,5'b00000,0);
        add(0,0,0, 1,0,0,1,0,5'b01110,0);
        add(0,0,0, 2,0,1,1,0,5'b00001,0);
        add(0,0,0, 0,1,0,1,0,5'b10000,0);
        add(0,0,0, 1,1,0,1,0,5'b01110,0);
        add(0,0,0, 2,1,0,1,0,5'b00001,0);
        add(0,0,0, 2,1,0,0,1,5'b00000,0);
        add(0,0,0, 2,1,0,0,0,5'b00000,0);
        // Zero length (stall ignored in IDLE)
        add(1,1,0, 2,1,0,0,0,5'b00000,0);
        add(0,0,0, 0,0,0,0,1,5'b00000,0);
        add(0,0,0, 0,0,0,0,0,5'b00000,0);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].sl, tbl[i].len);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].ua, tbl[i].ix, tbl[i].j,
                      tbl[i].b, tbl[i].d, tbl[i].en, tbl[i].e);
            advance();
        end
        drive(1'b0, 1'b0, '0);

        // Reset in the middle of a run: no done pulse afterwards
        load_basic();
        drive(1'b1, 1'b0, 8'd3);
        advance();
        drive(1'b0, 1'b0, '0);
        repeat (3) advance();
        rst = 1'b1;
        @(negedge clk);
        check_all("prerst", 0, 1, 0, 1, 0, 5'b10000, 0);
        advance();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_all($sformatf("postrst%0d", c), '0, '0, 0, 0, 0, 5'b0, 0);
            advance();
        end

        // Overflow: body without LAST runs off the ROM end
        for (int p = 0; p < int'(DEPTH); p++) rom[p] = 8'h20;
        drive(1'b1, 1'b0, 8'd1);
        advance();
        drive(1'b0, 1'b0, '0);
        for (int c = 0; c < int'(DEPTH); c++) begin
            @(negedge clk);
            check_all($sformatf("ovf%0d", c), W'(c), '0, 0, 1, 0, 5'b01000, 0);
            advance();
        end
        @(negedge clk);
        check_all("ovf_fin", W'(DEPTH - 1), '0, 0, 0, 1, 5'b0, 1);
        advance();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_all($sformatf("ovf_idle%0d", c), W'(DEPTH - 1), '0, 0, 0, 0, 5'b0, 1);
            advance();
        end
        drive(1'b1, 1'b0, 8'd1);
        advance();
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("ovf_restart.err", 32'(err), 32'(0));
        chk("ovf_restart.busy", 32'(busy), 32'(1));
        advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;

        // Randomized runs against a flattened expected-trace model
        for (int r = 0; r < 40; r++) begin
            exp_t          q[$];
            exp_t          ex;
            bit            ovf;
            int            blen, len;
            logic [W-1:0]  last_ua;
            logic [IW-1:0] last_ix;
            logic          sl;
            string         tag;

            ovf  = ($urandom_range(0, 7) == 0);
            blen = ovf ? int'(DEPTH) : int'($urandom_range(1, 6));
            len  = ovf ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 5));
            for (int p = 0; p < int'(DEPTH); p++)
                rom[p] = {1'b0, 5'($urandom), 2'($urandom)};
            if (!ovf) rom[blen-1][7] = 1'b1;

            if (ovf) begin
                for (int p = 0; p < int'(DEPTH); p++) begin
                    ex.ua = W'(p); ex.ix = '0; ex.j = 1'b0; ex.en = rom[p][6:2];
                    q.push_back(ex);
                end
            end else begin
                for (int i = 0; i < len; i++) begin
                    for (int p = 0; p < blen; p++) begin
                        ex.ua = W'(p); ex.ix = IW'(i);
                        ex.j  = (p == blen - 1) && (i != len - 1);
                        ex.en = rom[p][6:2];
                        q.push_back(ex);
                    end
                end
            end

            drive(1'b1, 1'($urandom), IW'(len));
            @(negedge clk);
            tag = $sformatf("rnd%0d.start", r);
            chk({tag, ".busy"}, 32'(busy), 32'(0));
            chk({tag, ".done"}, 32'(done), 32'(0));
            advance();

            last_ua = '0;
            last_ix = '0;
            for (int c = 0; q.size() > 0; c++) begin
                sl = ($urandom_range(0, 3) == 0);
                drive(1'($urandom), sl, IW'($urandom));
                @(negedge clk);
                tag = $sformatf("rnd%0d.c%0d", r, c);
                ex  = q[0];
                if (sl) begin
                    check_all(tag, ex.ua, ex.ix, 0, 1, 0, 5'b0, 0);
                end else begin
                    check_all(tag, ex.ua, ex.ix, ex.j, 1, 0, ex.en, 0);
                    last_ua = ex.ua;
                    last_ix = ex.ix;
                    void'(q.pop_front());
                end
                advance();
            end

            drive(1'($urandom), 1'($urandom), IW'($urandom));
            @(negedge clk);
            check_all($sformatf("rnd%0d.fin", r), last_ua, last_ix, 0, 0, 1, 5'b0, ovf);
            advance();
            drive(1'b0, 1'b0, '0);
            @(negedge clk);
            check_all($sformatf("rnd%0d.idle", r), last_ua, last_ix, 0, 0, 0, 5'b0, ovf);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
